// File: rtl/outer1bits_peel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// outer1bits_peel_ctrl_pkg
//
// Purpose: shared definitions for the outer1bits peel controller slice.
//   - default values for the data width and the word counter width
//   - the two-state controller enum (IDLE, EMIT) plus plain localparam
//     encodings of the same states for code that keeps state in a
//     bare logic vector
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package outer1bits_peel_ctrl_pkg;

   // Default width of the input word and of each one-hot output.
   localparam int DEF_WIDTH = 4;

   // Default width of the processed-word counter.
   localparam int DEF_CNT_W = 8;

   // Controller states. IDLE accepts a word, EMIT streams its pairs.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } peel_state_e;

   // Bare-vector encodings of the enum, used by the state register.
   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_EMIT = EMIT;

endpackage : outer1bits_peel_ctrl_pkg

// File: rtl/outer1bits_peel_ctrl_outer1bits.sv
// -----------------------------------------------------------------------------
// outer1bits_peel_ctrl_outer1bits
//
// Purpose: purely combinational "outer 1 bits" decomposition of a word.
//   data_left_o  is the one-hot MSB-most set bit of data_i (0 if none).
//   data_right_o is the one-hot LSB-most set bit of data_i (0 if none).
//   With a single set bit both outputs equal that bit. Both outputs are
//   forced to zero while data_val_i is low.
//
// Ports:
//   data_i        in  WIDTH  word to decompose
//   data_val_i    in  1      data_i is valid (gates the outputs)
//   data_left_o   out WIDTH  one-hot leftmost set bit, or zero
//   data_right_o  out WIDTH  one-hot rightmost set bit, or zero
// -----------------------------------------------------------------------------
module outer1bits_peel_ctrl_outer1bits
   import outer1bits_peel_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_val_i,
   output logic [WIDTH-1:0] data_left_o,
   output logic [WIDTH-1:0] data_right_o
);

   logic [WIDTH-1:0] left_raw;
   logic [WIDTH-1:0] right_raw;

   // Leftmost: scan upward, every later (higher) set bit overrides the
   // earlier choice, so the final value is the MSB-most set bit.
   always_comb begin
      left_raw = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) begin
            left_raw    = '0;
            left_raw[i] = 1'b1;
         end
      end
   end

   // Rightmost: classic two's-complement isolate-lowest-set-bit trick.
   assign right_raw = data_i & (~data_i + WIDTH'(1));

   assign data_left_o  = data_val_i ? left_raw  : '0;
   assign data_right_o = data_val_i ? right_raw : '0;

endmodule : outer1bits_peel_ctrl_outer1bits

// File: rtl/outer1bits_peel_ctrl.sv
// -----------------------------------------------------------------------------
// outer1bits_peel_ctrl
//
// Purpose: accepts a WIDTH-bit word and peels it into a stream of
// (leftmost, rightmost) one-hot bit pairs, two set bits per beat, from the
// outside in. A word with popcount p yields max(1, ceil(p/2)) beats; a zero
// word yields a single all-zero beat flagged last. Words are handled one at
// a time: the block never accepts a new word while it is emitting.
//
// Handshakes (both sides): a transfer happens on a rising clk_i edge where
// the valid and the matching ready are both high. The producer of valid must
// hold its payload stable until that edge; ready may change freely. Here
// data_ready_o is high exactly in IDLE and data_val_o exactly in EMIT, so a
// stalled beat (data_ready_i low) keeps every output unchanged.
//
// Ports:
//   clk_i         in  1       clock, rising edge
//   rst_i         in  1       asynchronous active-high reset
//   data_i        in  WIDTH   word to decompose
//   data_val_i    in  1       data_i valid
//   data_ready_o  out 1       block can accept a word (IDLE)
//   data_left_o   out WIDTH   one-hot leftmost remaining set bit, or zero
//   data_right_o  out WIDTH   one-hot rightmost remaining set bit, or zero
//   data_val_o    out 1       output pair valid (EMIT)
//   data_ready_i  in  1       downstream accepts the pair
//   data_last_o   out 1       current beat is the last one for the word
//   beat_idx_o    out IDX_W   beat index within the word, from 0
//   word_cnt_o    out CNT_W   number of fully emitted words, wrapping
//   dbg_state_o   out 1       controller state (IDLE/EMIT encoding)
// -----------------------------------------------------------------------------
module outer1bits_peel_ctrl
   import outer1bits_peel_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_val_i,
   output logic             data_ready_o,
   output logic [WIDTH-1:0] data_left_o,
   output logic [WIDTH-1:0] data_right_o,
   output logic             data_val_o,
   input  logic             data_ready_i,
   output logic             data_last_o,
   output logic [IDX_W-1:0] beat_idx_o,
   output logic [CNT_W-1:0] word_cnt_o,
   output logic [0:0]       dbg_state_o
);

   // --------------------------------------------------------------------------
   // Registers (the only sequential elements of the block)
   // --------------------------------------------------------------------------
   logic [0:0]       state_q;
   logic [WIDTH-1:0] residue_q;
   logic [IDX_W-1:0] beat_idx_q;
   logic [CNT_W-1:0] word_cnt_q;

   // --------------------------------------------------------------------------
   // Decomposition of the residue
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] left_w;
   logic [WIDTH-1:0] right_w;
   logic [WIDTH-1:0] residue_next_w;
   logic             last_w;
   logic             in_emit;
   logic             in_fire;
   logic             beat_fire;

   outer1bits_peel_ctrl_outer1bits #(
      .WIDTH (WIDTH)
   ) u_outer1bits (
      .data_i       (residue_q),
      .data_val_i   (1'b1),
      .data_left_o  (left_w),
      .data_right_o (right_w)
   );

   // Residue after removing the pair currently on the outputs. When it is
   // empty this beat finishes the word; a zero residue is therefore its own
   // (single) last beat.
   assign residue_next_w = residue_q & ~(left_w | right_w);
   assign last_w         = (residue_next_w == '0);

   assign in_emit   = (state_q == ST_EMIT);
   assign in_fire   = (state_q == ST_IDLE) && data_val_i;
   assign beat_fire = in_emit && data_ready_i;

   // --------------------------------------------------------------------------
   // Controller
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         residue_q  <= '0;
         beat_idx_q <= '0;
         word_cnt_q <= '0;
      end else begin
         if (in_fire) begin
            residue_q  <= data_i;
            beat_idx_q <= '0;
            state_q    <= ST_EMIT;
         end else if (beat_fire) begin
            if (last_w) begin
               // Word complete: clear the residue so IDLE never carries
               // leftover bits into the next word.
               residue_q  <= '0;
               beat_idx_q <= '0;
               word_cnt_q <= word_cnt_q + CNT_W'(1);
               state_q    <= ST_IDLE;
            end else begin
               residue_q  <= residue_next_w;
               beat_idx_q <= beat_idx_q + IDX_W'(1);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign data_ready_o = ~in_emit;
   assign data_val_o   = in_emit;
   // Pair and last flag only carry meaning while a beat is offered.
   assign data_left_o  = in_emit ? left_w  : '0;
   assign data_right_o = in_emit ? right_w : '0;
   assign data_last_o  = in_emit & last_w;
   assign beat_idx_o   = beat_idx_q;
   assign word_cnt_o   = word_cnt_q;
   assign dbg_state_o  = state_q;

endmodule : outer1bits_peel_ctrl

// File: tb/tb_outer1bits_peel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_outer1bits_peel_ctrl
//
// Self-checking bench for outer1bits_peel_ctrl (WIDTH=4, CNT_W=8). Expected
// beats come from a bit-position model of the outer-bit peeling rules and are
// queued per word; the bench compares each offered beat against the queue.
// -----------------------------------------------------------------------------
module tb_outer1bits_peel_ctrl;
   import outer1bits_peel_ctrl_pkg::*;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;
   localparam int IDX_W = 2;
   localparam int BW    = 2 * WIDTH + 1 + IDX_W;  // {left, right, last, idx}

   // --------------------------------------------------------------------------
   // Clock / reset
   // --------------------------------------------------------------------------
   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic [WIDTH-1:0] data_i = '0;
   logic             data_val_i = 1'b0;
   logic             data_ready_o;
   logic [WIDTH-1:0] data_left_o;
   logic [WIDTH-1:0] data_right_o;
   logic             data_val_o;
   logic             data_ready_i = 1'b0;
   logic             data_last_o;
   logic [IDX_W-1:0] beat_idx_o;
   logic [CNT_W-1:0] word_cnt_o;
   logic [0:0]       dbg_state_o;

   always #5 clk_i = ~clk_i;

   outer1bits_peel_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .data_i       (data_i),
      .data_val_i   (data_val_i),
      .data_ready_o (data_ready_o),
      .data_left_o  (data_left_o),
      .data_right_o (data_right_o),
      .data_val_o   (data_val_o),
      .data_ready_i (data_ready_i),
      .data_last_o  (data_last_o),
      .beat_idx_o   (beat_idx_o),
      .word_cnt_o   (word_cnt_o),
      .dbg_state_o  (dbg_state_o)
   );

   // --------------------------------------------------------------------------
   // Scoreboard
   // --------------------------------------------------------------------------
   logic [BW-1:0]    exp_q[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   int               checks = 0;
   int               errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: repeatedly strip the highest and lowest set bit
   // positions of the remaining word; a zero word is one empty last beat.
   task automatic model_word(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] l;
      logic [WIDTH-1:0] rt;
      int               hi;
      int               lo;
      int               idx;
      r   = w;
      idx = 0;
      if (w == '0) begin
         exp_q.push_back({4'b0000, 4'b0000, 1'b1, 2'd0});
      end else begin
         while (r != '0) begin
            hi = -1;
            lo = -1;
            for (int i = 0; i < WIDTH; i++) begin
               if (r[i]) begin
                  if (lo < 0) lo = i;
                  hi = i;
               end
            end
            l  = WIDTH'(1 << hi);
            rt = WIDTH'(1 << lo);
            r  = r & ~(l | rt);
            exp_q.push_back({l, rt, (r == '0), IDX_W'(idx)});
            idx++;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_ready"}, 32'(data_ready_o), 32'd1);
      check_eq({tag, "_val"},   32'(data_val_o),   32'd0);
      check_eq({tag, "_state"}, 32'(dbg_state_o),  32'(IDLE));
      check_eq({tag, "_cnt"},   32'(word_cnt_o),   32'(exp_cnt));
   endtask

   // --------------------------------------------------------------------------
   // Driver: offer one word, then consume its beats. fixed_stall > 0 holds
   // data_ready_i low for that many cycles on the first beat; otherwise the
   // downstream stalls at random when rand_stall is set.
   // --------------------------------------------------------------------------
   task automatic run_word(input logic [WIDTH-1:0] w, input int fixed_stall, input bit rand_stall);
      int            guard;
      int            stall_left;
      int            beats;
      int            exp_beats;
      int            pop;
      logic [BW-1:0] got;
      bit            take;
      @(negedge clk_i);
      check_idle("pre_idle");
      model_word(w);
      data_i     = w;
      data_val_i = 1'b1;
      @(negedge clk_i);
      data_val_i = 1'b0;
      data_i     = WIDTH'($urandom_range(0, 15));
      guard      = 0;
      beats      = 0;
      stall_left = fixed_stall;
      while (exp_q.size() > 0 && guard < 40) begin
         got = {data_left_o, data_right_o, data_last_o, beat_idx_o};
         check_eq("emit_val",   32'(data_val_o),   32'd1);
         check_eq("emit_ready", 32'(data_ready_o), 32'd0);
         check_eq("beat",       32'(got),          32'(exp_q[0]));
         if (stall_left > 0) begin
            take = 1'b0;
            stall_left--;
         end else if (rand_stall) begin
            take = ($urandom_range(0, 99) >= 30);
         end else begin
            take = 1'b1;
         end
         data_ready_i = take;
         @(negedge clk_i);
         if (take) begin
            void'(exp_q.pop_front());
            beats++;
         end
         guard++;
      end
      data_ready_i = 1'b0;
      if (exp_q.size() > 0) begin
         check_eq("beat_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      pop       = $countones(w);
      exp_beats = (pop == 0) ? 1 : (pop + 1) / 2;
      check_eq("beat_count", 32'(beats), 32'(exp_beats));
      exp_cnt = exp_cnt + CNT_W'(1);
      check_idle("post_idle");
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i   = 1'b0;
      exp_cnt = '0;
      exp_q.delete();
   endtask

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin
      // Reset state while rst_i is held
      repeat (2) @(negedge clk_i);
      check_eq("rst_ready", 32'(data_ready_o), 32'd1);
      check_eq("rst_val",   32'(data_val_o),   32'd0);
      check_eq("rst_last",  32'(data_last_o),  32'd0);
      check_eq("rst_left",  32'(data_left_o),  32'd0);
      check_eq("rst_right", 32'(data_right_o), 32'd0);
      check_eq("rst_idx",   32'(beat_idx_o),   32'd0);
      check_eq("rst_cnt",   32'(word_cnt_o),   32'd0);
      rst_i = 1'b0;

      // Directed words
      run_word(4'b1011, 0, 1'b0);
      run_word(4'b0000, 0, 1'b0);
      run_word(4'b0110, 3, 1'b0);
      run_word(4'b1111, 0, 1'b0);
      run_word(4'b1000, 2, 1'b0);

      // Reset mid-word: 1111, consume the first beat, then reset
      @(negedge clk_i);
      data_i     = 4'b1111;
      data_val_i = 1'b1;
      @(negedge clk_i);
      data_val_i   = 1'b0;
      data_ready_i = 1'b1;
      check_eq("mid_beat0", 32'({data_left_o, data_right_o, data_last_o}), 32'({4'b1000, 4'b0001, 1'b0}));
      @(negedge clk_i);
      data_ready_i = 1'b0;
      check_eq("mid_beat1", 32'({data_left_o, data_right_o, data_last_o}), 32'({4'b0100, 4'b0010, 1'b1}));
      #2 rst_i = 1'b1;
      #1;
      check_eq("async_val",   32'(data_val_o),   32'd0);
      check_eq("async_ready", 32'(data_ready_o), 32'd1);
      check_eq("async_cnt",   32'(word_cnt_o),   32'd0);
      check_eq("async_last",  32'(data_last_o),  32'd0);
      check_eq("async_pair",  32'({data_left_o, data_right_o}), 32'd0);
      @(negedge clk_i);
      rst_i   = 1'b0;
      exp_cnt = '0;
      run_word(4'b0001, 0, 1'b0);

      // Randomized words with random downstream stalls
      for (int n = 0; n < 150; n++) begin
         run_word(WIDTH'($urandom_range(0, 15)), 0, 1'b1);
      end

      // Counter wrap over 256 words
      do_reset();
      for (int n = 0; n < 256; n++) begin
         run_word(4'b0001, 0, 1'b0);
         if (n == 254) check_eq("cnt_255", 32'(word_cnt_o), 32'd255);
      end
      check_eq("cnt_wrap", 32'(word_cnt_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_outer1bits_peel_ctrl

// File: doc/outer1bits_peel_ctrl.md
OUTER1BITS_PEEL_CTRL -- requirements
Module: outer1bits_peel_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, width of the input word and of each one-hot output; 4 is the only value that must be supported.
REQ-002 Parameter: CNT_W, 8, width of the processed-word counter.
REQ-003 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_i  in  1  reset, asynchronous, active-high.
REQ-005 Port: data_i  in  WIDTH  input word to decompose.
REQ-006 Port: data_val_i  in  1  data_i is valid.
REQ-007 Port: data_ready_o  out  1  block accepts a word; transfer occurs when data_val_i and data_ready_o are both high.
REQ-008 Port: data_left_o  out  WIDTH  one-hot leftmost remaining 1 bit, or zero.
REQ-009 Port: data_right_o  out  WIDTH  one-hot rightmost remaining 1 bit, or zero.
REQ-010 Port: data_val_o  out  1  output pair is valid.
REQ-011 Port: data_ready_i  in  1  downstream accepts the pair; a beat occurs when data_val_o and data_ready_i are both high.
REQ-012 Port: data_last_o  out  1  current beat is the final beat for the word.
REQ-013 Port: beat_idx_o  out  $clog2(WIDTH)  index of the current beat within the word, starting at 0.
REQ-014 Port: word_cnt_o  out  CNT_W  count of fully emitted words, wrapping.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and EMIT.
REQ-016 In IDLE, data_ready_o SHALL be 1 and data_val_o SHALL be 0.
REQ-017 In EMIT, data_ready_o SHALL be 0 and data_val_o SHALL be 1.
REQ-018 On an input transfer in IDLE, data_i SHALL be latched into the residue register, beat_idx SHALL be cleared to 0, and the FSM SHALL enter EMIT on the next edge; the first pair is valid one cycle after acceptance.
REQ-019 In EMIT, data_left_o and data_right_o SHALL equal the outer1bits decomposition of the residue: the MSB-most and LSB-most set bits.
REQ-020 When the residue has a single set bit, data_left_o and data_right_o SHALL both equal that bit.
REQ-021 When the residue is zero, data_left_o and data_right_o SHALL both be 0.
REQ-022 data_last_o SHALL equal ((residue & ~(data_left_o | data_right_o)) == 0).
REQ-023 A zero input word SHALL produce exactly one beat: left=0, right=0, last=1.
REQ-024 On a beat with data_last_o=0, the residue SHALL be cleared of data_left_o | data_right_o and beat_idx SHALL increment.
REQ-025 On a beat with data_last_o=1, the FSM SHALL return to IDLE, word_cnt SHALL increment modulo 2^CNT_W, and beat_idx SHALL return to 0.
REQ-026 While data_val_o=1 and data_ready_i=0, all outputs SHALL hold stable.
REQ-027 One idle cycle (data_ready_o=1) SHALL separate consecutive words; there is no overlap of input acceptance and emission.
REQ-028 The number of beats per word SHALL be max(1, ceil(popcount/2)).

Reset
REQ-029 While rst_i is high, state SHALL be IDLE and the residue, beat_idx_o and word_cnt_o SHALL be 0.
REQ-030 While rst_i is high, data_val_o and data_last_o SHALL be 0, data_left_o and data_right_o SHALL be 0, and data_ready_o SHALL be 1.
REQ-031 Reset asserted mid-word SHALL abandon the word immediately (asynchronously), with no further beats emitted for it and word_cnt_o not incremented.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, EMIT) and default constants for WIDTH and CNT_W.
REQ-033 The block SHALL instantiate exactly one outer1bits sub-module fed from the residue register, with data_val_i tied high, and SHALL add no duplicate decomposition logic.
REQ-034 The state, residue, beat_idx and word_cnt registers SHALL be the only sequential elements.

Verification
REQ-035 Input 1011, data_ready_i=1 -> beat (1000, 0001, last=0, idx=0), then beat (0010, 0010, last=1, idx=1); word_cnt_o increments 0->1.
REQ-036 Input 0000 -> exactly one beat (0000, 0000, last=1); FSM returns to IDLE.
REQ-037 Input 0110 with data_ready_i held low for 3 cycles -> outputs held at (0100, 0010, last=1) for 4 cycles, then one beat and return to IDLE.
REQ-038 Input 1111 -> beats (1000, 0001, last=0), then (0100, 0010, last=1); data_ready_o=0 throughout emission and high one cycle later.
REQ-039 Input 1111, rst_i pulsed after the first beat -> data_val_o=0 at once, word_cnt_o=0, data_ready_o=1; a new word 0001 is then accepted and yields (0001, 0001, last=1).
REQ-040 256 consecutive words of 0001 -> word_cnt_o wraps from 255 to 0.
